// File: rtl/sreg_ctrl_pkg.sv
// Shared types and helpers for the shift-register load controller.
package sreg_ctrl_pkg;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StShift   = 3'd2,
    StCapture = 3'd3,
    StHold    = 3'd4
  } state_e;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [63:0] bit_rev(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) begin
        r[6'(i)] = v[6'(w - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sreg_bit_counter.sv
// Bit-position counter for the serialiser: clear-to-zero, increment, and a flag at
// the last bit position. Wraps to zero after the last position so the count never
// leaves 0..WIDTH-1, even when WIDTH is not a power of two.
module sreg_bit_counter #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  assign tc = (cnt == LastIdx);

  // Count register: load and reset both return to bit position zero.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sreg_load_ctrl.sv
// Sequencer for a serial-in/parallel-out shift register: takes a word, clears the
// register, shifts the word in one bit per clock, captures the parallel output and
// hands it on. The captured word is compared with what was sent, which makes the
// external shift register a loopback self-test.
module sreg_load_ctrl
  import sreg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          CHECK     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   sreg_sinp,
  output logic                   sreg_en,
  output logic                   sreg_clr,
  input  logic [WIDTH-1:0]       sreg_pout,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned   CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] exp_word;
  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic [CW-1:0]    bit_idx;

  sreg_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == StClear),
    .inc   (state_q == StShift),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // The register shifts toward higher index, so the first bit sent ends up in the MSB.
  // Sending LSB first therefore lands the word bit-reversed.
  assign bit_idx  = MSB_FIRST ? LastIdx - cnt : cnt;
  assign exp_word = MSB_FIRST ? word_q : WIDTH'(bit_rev(64'(word_q), WIDTH));

  // Shift-register controls and handshake status decoded from the state register.
  always_comb begin
    in_ready  = !reset && (state_q == StIdle);
    busy      = (state_q != StIdle);
    sreg_clr  = reset || (state_q == StClear);
    sreg_en   = !reset && (state_q == StShift);
    sreg_sinp = sreg_en && word_q[bit_idx];
  end

  // Frame sequencing, word capture, result register, checker and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q  <= in_data;
            state_q <= StClear;
          end
        end
        StClear: begin
          state_q <= StShift;
        end
        StShift: begin
          if (cnt_tc) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          out_data  <= sreg_pout;
          out_valid <= 1'b1;
          if (CHECK && (sreg_pout != exp_word)) begin
            err <= 1'b1;
          end
          state_q <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_load_ctrl.sv
// Directed bench for sreg_load_ctrl: an MSB-first instance and an LSB-first instance,
// each driving a behavioural shift-register model.
module tb_sreg_load_ctrl;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] in_data, sreg_pout, out_data;
  logic         in_valid, in_ready, sreg_sinp, sreg_en, sreg_clr;
  logic         out_valid, out_ready, busy, err;
  logic [7:0]   frame_cnt;

  logic [W-1:0] in_data_l, sreg_pout_l, out_data_l;
  logic         in_valid_l, in_ready_l, sreg_sinp_l, sreg_en_l, sreg_clr_l;
  logic         out_valid_l, out_ready_l, busy_l, err_l;
  logic [7:0]   frame_cnt_l;

  logic         corrupt;
  logic [W-1:0] pout_m, pout_ml;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int acc_t[$];

  sreg_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sreg_sinp(sreg_sinp), .sreg_en(sreg_en), .sreg_clr(sreg_clr), .sreg_pout(sreg_pout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .err(err), .frame_cnt(frame_cnt)
  );

  sreg_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .CHECK(1'b1)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .sreg_sinp(sreg_sinp_l), .sreg_en(sreg_en_l),
    .sreg_clr(sreg_clr_l), .sreg_pout(sreg_pout_l), .out_data(out_data_l),
    .out_valid(out_valid_l), .out_ready(out_ready_l), .busy(busy_l), .err(err_l),
    .frame_cnt(frame_cnt_l)
  );

  // Shift-register models; the first can be made to flip bit 2 of its output.
  always @(posedge clk) begin
    if (sreg_clr) pout_m <= '0;
    else if (sreg_en) pout_m <= {pout_m[W-2:0], sreg_sinp};
    if (sreg_clr_l) pout_ml <= '0;
    else if (sreg_en_l) pout_ml <= {pout_ml[W-2:0], sreg_sinp_l};
  end
  assign sreg_pout   = pout_m ^ (corrupt ? 4'b0100 : 4'b0000);
  assign sreg_pout_l = pout_ml;

  // Cycle counter and acceptance-edge log for the MSB-first instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_t.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full frame on the MSB-first instance; call from IDLE with out_ready high.
  task automatic send_frame(input logic [W-1:0] d, output logic [W-1:0] got,
                            output logic got_err);
    int k;
    in_data  = d;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick;
      k++;
    end
    check_eq("frame_out_valid_seen", 32'(out_valid), 32'd1);
    got     = out_data;
    got_err = err;
    tick;
  endtask

  initial begin
    logic [W-1:0] seq1;
    logic [W-1:0] outs[2];
    logic [W-1:0] got;
    logic         gerr;
    logic         seen;
    int           n_out;
    int           k;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; corrupt = 1'b0;
    in_valid_l = 1'b0; in_data_l = '0; out_ready_l = 1'b1;
    tick;
    tick;
    check_eq("rst_sreg_clr", 32'(sreg_clr), 32'd1);
    check_eq("rst_sreg_en", 32'(sreg_en), 32'd0);
    check_eq("rst_sinp", 32'(sreg_sinp), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single frame 1010, MSB first
    seq1 = 4'b1010;
    in_data = seq1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check_eq("t1_clear_clr", 32'(sreg_clr), 32'd1);
    check_eq("t1_clear_busy", 32'(busy), 32'd1);
    check_eq("t1_clear_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("t1_shift_en", 32'(sreg_en), 32'd1);
      check_eq("t1_shift_sinp", 32'(sreg_sinp), 32'(seq1[3-i]));
    end
    tick;
    check_eq("t1_capture_out_valid", 32'(out_valid), 32'd0);
    check_eq("t1_capture_en", 32'(sreg_en), 32'd0);
    tick;
    check_eq("t1_cycle6_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_out_data", 32'(out_data), 32'hA);
    check_eq("t1_err", 32'(err), 32'd0);
    tick;
    check_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check_eq("t1_idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("t1_out_valid_clr", 32'(out_valid), 32'd0);

    // 2: back-to-back F then 0 with in_valid held high
    acc_t.delete();
    n_out = 0;
    in_data = 4'hF; in_valid = 1'b1;
    k = 0;
    while (n_out < 2 && k < 40) begin
      tick;
      k++;
      if (acc_t.size() == 1) in_data = 4'h0;
      if (acc_t.size() >= 2) in_valid = 1'b0;
      if (out_valid) begin
        outs[n_out] = out_data;
        n_out++;
      end
    end
    in_valid = 1'b0;
    tick;
    check_eq("t2_n_out", 32'(n_out), 32'd2);
    check_eq("t2_n_acc", 32'(acc_t.size()), 32'd2);
    if (n_out == 2) begin
      check_eq("t2_first_data", 32'(outs[0]), 32'hF);
      check_eq("t2_second_data", 32'(outs[1]), 32'h0);
    end
    // IDLE, CLEAR, four SHIFT cycles, CAPTURE, HOLD between acceptance edges
    if (acc_t.size() >= 2) check_eq("t2_acc_spacing", 32'(acc_t[1] - acc_t[0]), 32'd8);
    check_eq("t2_frame_cnt", 32'(frame_cnt), 32'd3);

    // 3: stall in HOLD for 5 cycles
    out_ready = 1'b0;
    in_data = 4'b1100; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick;
      k++;
    end
    check_eq("t3_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t3_hold_data", 32'(out_data), 32'hC);
      check_eq("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    check_eq("t3_release_busy", 32'(busy), 32'd0);
    check_eq("t3_release_in_ready", 32'(in_ready), 32'd1);
    check_eq("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // 4: reset in the 2nd SHIFT cycle
    in_data = 4'b0101; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    check_eq("t4_in_shift", 32'(sreg_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t4_rst_clr", 32'(sreg_clr), 32'd1);
    check_eq("t4_rst_en", 32'(sreg_en), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_in_ready", 32'(in_ready), 32'd1);
    check_eq("t4_out_valid", 32'(out_valid), 32'd0);
    check_eq("t4_out_data", 32'(out_data), 32'd0);
    check_eq("t4_frame_cnt", 32'(frame_cnt), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen = seen | out_valid;
    end
    check_eq("t4_no_partial_output", 32'(seen), 32'd0);

    // 5: corrupted bit 2 sets sticky err
    corrupt = 1'b1;
    send_frame(4'b0110, got, gerr);
    check_eq("t5_corrupt_data", 32'(got), 32'h2);
    check_eq("t5_corrupt_err", 32'(gerr), 32'd1);
    corrupt = 1'b0;
    send_frame(4'b0011, got, gerr);
    check_eq("t5_clean_data", 32'(got), 32'h3);
    check_eq("t5_err_sticky", 32'(gerr), 32'd1);
    check_eq("t5_frame_cnt", 32'(frame_cnt), 32'd2);

    // 6: 256 frames wrap frame_cnt; then LSB-first instance
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    check_eq("t6_err_cleared", 32'(err), 32'd0);
    for (int i = 1; i <= 256; i++) begin
      send_frame(W'(i), got, gerr);
      if (i == 255) check_eq("t6_frame_cnt_255", 32'(frame_cnt), 32'd255);
    end
    check_eq("t6_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    check_eq("t6_last_data", 32'(got), 32'h0);
    check_eq("t6_err_clean", 32'(err), 32'd0);

    in_data_l = 4'b0001; in_valid_l = 1'b1;
    tick;
    in_valid_l = 1'b0;
    k = 0;
    while (!out_valid_l && k < 20) begin
      tick;
      k++;
    end
    check_eq("t6_lsb_out_valid", 32'(out_valid_l), 32'd1);
    check_eq("t6_lsb_out_data", 32'(out_data_l), 32'h8);
    check_eq("t6_lsb_err", 32'(err_l), 32'd0);
    tick;
    check_eq("t6_lsb_frame_cnt", 32'(frame_cnt_l), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
